// File: rtl/lcd_pkg.sv
// Shared state encoding, HD44780 command bytes and helpers for the character-LCD controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP   = 3'd0,
        INIT    = 3'd1,
        CLRWAIT = 3'd2,
        IDLE    = 3'd3,
        ROWADDR = 3'd4,
        CHARS   = 3'd5
    } lcd_state_e;

    localparam logic [7:0] FUNC_SET   = 8'h38;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] ENTRY_MODE = 8'h06;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] SET_DDRAM  = 8'h80;

    // Byte transmitter phase codes; IDLE means no transfer in flight.
    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_ENABLE = 2'd2;
    localparam logic [1:0] PH_HOLD   = 2'd3;

    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET;
            2'd1:    return DISP_ON;
            2'd2:    return ENTRY_MODE;
            default: return CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Drives one byte onto the panel bus: setup, enable-high and hold phases of CLK_DIV cycles each.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] data_i,
    output logic       lcd_en_o,
    output logic       lcd_rs_o,
    output logic [7:0] lcd_db_o,
    output logic       done_o,
    output logic [1:0] phase_o
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [1:0]       phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             div_end;

    assign div_end = (div_q == DIV_LAST);

    // A start on the last hold cycle chains the next byte with no gap.
    always_comb begin
        phase_d = phase_q;
        div_d   = div_q;
        en_d    = en_q;
        rs_d    = rs_q;
        db_d    = db_q;
        if (start_i) begin
            phase_d = PH_SETUP;
            div_d   = '0;
            en_d    = 1'b0;
            rs_d    = rs_i;
            db_d    = data_i;
        end else if (phase_q != PH_IDLE) begin
            if (div_end) begin
                div_d = '0;
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_ENABLE;
                        en_d    = 1'b1;
                    end
                    PH_ENABLE: begin
                        phase_d = PH_HOLD;
                        en_d    = 1'b0;
                    end
                    default: phase_d = PH_IDLE;
                endcase
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            div_q   <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
        end else begin
            phase_q <= phase_d;
            div_q   <= div_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
        end
    end

    assign done_o   = (phase_q == PH_HOLD) && div_end;
    assign phase_o  = phase_q;
    assign lcd_en_o = en_q;
    assign lcd_rs_o = rs_q;
    assign lcd_db_o = db_q;

endmodule

// File: rtl/lcd_char_ctrl.sv
// HD44780 character-LCD controller: power-up/init sequence, then refresh passes
// from a host-writable NUM_ROWS x NUM_COLS character buffer.
module lcd_char_ctrl
    import lcd_pkg::*;
#(
    parameter int NUM_COLS     = 16,
    parameter int NUM_ROWS     = 2,
    parameter int CLK_DIV      = 2,
    parameter int INIT_WAIT    = 100,
    parameter int CLEAR_WAIT   = 20,
    parameter int AUTO_REFRESH = 0,
    localparam int TOTAL       = NUM_ROWS * NUM_COLS,
    localparam int ADDR_W      = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              refresh_req,
    output logic              busy,
    output logic              lcd_en,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic [7:0]        lcd_db,
    output logic              lcd_rst
);
    localparam int WAIT_MAX = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    localparam logic [2:0] S_PWRUP   = PWRUP;
    localparam logic [2:0] S_INIT    = INIT;
    localparam logic [2:0] S_CLRWAIT = CLRWAIT;
    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_ROWADDR = ROWADDR;
    localparam logic [2:0] S_CHARS   = CHARS;

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              pend_q, pend_d;
    logic              busy_q;
    logic [7:0]        chr_q [TOTAL];

    logic              tx_start, tx_rs, tx_done;
    logic [7:0]        tx_data;
    logic [1:0]        tx_phase;
    logic              pass_go;

    function automatic logic [ADDR_W-1:0] char_idx(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
        return ADDR_W'(int'(r) * NUM_COLS + int'(c));
    endfunction

    // Every byte is launched on the cycle the previous one reports done, so
    // characters are read from the buffer at the moment their setup begins.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        cmd_d    = cmd_q;
        row_d    = row_q;
        col_d    = col_q;
        tx_start = 1'b0;
        tx_rs    = 1'b0;
        tx_data  = 8'h00;
        pass_go  = 1'b0;
        case (state_q)
            S_PWRUP: begin
                if (wait_q == WAIT_W'(INIT_WAIT - 1)) begin
                    state_d  = S_INIT;
                    cmd_d    = 2'd0;
                    tx_start = 1'b1;
                    tx_data  = init_cmd(2'd0);
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_INIT: begin
                if (tx_done) begin
                    if (cmd_q == 2'd3) begin
                        state_d = S_CLRWAIT;
                        wait_d  = '0;
                    end else begin
                        cmd_d    = cmd_q + 2'd1;
                        tx_start = 1'b1;
                        tx_data  = init_cmd(cmd_q + 2'd1);
                    end
                end
            end
            S_CLRWAIT: begin
                if (wait_q == WAIT_W'(CLEAR_WAIT - 1)) state_d = S_IDLE;
                else                                    wait_d  = wait_q + 1'b1;
            end
            S_IDLE: begin
                if ((pend_q || refresh_req || AUTO_REFRESH != 0) && tx_phase == PH_IDLE) begin
                    pass_go  = 1'b1;
                    row_d    = '0;
                    state_d  = S_ROWADDR;
                    tx_start = 1'b1;
                    tx_data  = SET_DDRAM | row_base(2'd0);
                end
            end
            S_ROWADDR: begin
                if (tx_done) begin
                    col_d    = '0;
                    state_d  = S_CHARS;
                    tx_start = 1'b1;
                    tx_rs    = 1'b1;
                    tx_data  = chr_q[char_idx(row_q, '0)];
                end
            end
            S_CHARS: begin
                if (tx_done) begin
                    if (col_q != COL_LAST) begin
                        col_d    = col_q + 1'b1;
                        tx_start = 1'b1;
                        tx_rs    = 1'b1;
                        tx_data  = chr_q[char_idx(row_q, col_q + 1'b1)];
                    end else if (row_q != ROW_LAST) begin
                        row_d    = row_q + 1'b1;
                        state_d  = S_ROWADDR;
                        tx_start = 1'b1;
                        tx_data  = SET_DDRAM | row_base(2'(row_q + 1'b1));
                    end else if (AUTO_REFRESH != 0) begin
                        pass_go  = 1'b1;
                        row_d    = '0;
                        state_d  = S_ROWADDR;
                        tx_start = 1'b1;
                        tx_data  = SET_DDRAM | row_base(2'd0);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_PWRUP;
        endcase
    end

    // Requests arriving while busy collapse into a single follow-up pass.
    always_comb begin
        pend_d = pend_q;
        if (refresh_req && state_q != S_IDLE) pend_d = 1'b1;
        else if (pass_go)                     pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PWRUP;
            wait_q  <= '0;
            cmd_q   <= 2'd0;
            row_q   <= '0;
            col_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cmd_q   <= cmd_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pend_q  <= pend_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TOTAL; i++) chr_q[i] <= 8'h20;
        end else if (wr_en && (32'(wr_addr) < TOTAL)) begin
            chr_q[wr_addr] <= wr_data;
        end
    end

    lcd_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .start_i  (tx_start),
        .rs_i     (tx_rs),
        .data_i   (tx_data),
        .lcd_en_o (lcd_en),
        .lcd_rs_o (lcd_rs),
        .lcd_db_o (lcd_db),
        .done_o   (tx_done),
        .phase_o  (tx_phase)
    );

    assign busy    = busy_q;
    assign lcd_rw  = 1'b0;
    assign lcd_rst = ~rst;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Scoreboard bench for lcd_char_ctrl: expected panel bytes are queued at stimulus time
// and popped by a monitor on every lcd_en rise.
module tb_lcd_char_ctrl;
    localparam int NC = 10, NR = 3, TOTAL = NC * NR, CD = 2, IW = 100, CW = 20;
    localparam int AW = $clog2(TOTAL);
    localparam int PASS_LEN = NR * (NC + 1) * 3 * CD;

    logic          clk = 1'b0, rst = 1'b1, wr_en = 1'b0, refresh_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = 8'h00;
    logic          busy, lcd_en, lcd_rs, lcd_rw, lcd_rst;
    logic [7:0]    lcd_db;

    logic          rst_a = 1'b1, wr_en_a = 1'b0, req_a = 1'b0;
    logic [1:0]    wr_addr_a = 2'd0;
    logic [7:0]    wr_data_a = 8'h00;
    logic          busy_a, en_a, rs_a, rw_a, lrst_a;
    logic [7:0]    db_a;

    int            tests = 0, fails = 0;
    logic [8:0]    exp_q[$];
    logic [7:0]    model[TOTAL];
    logic          auto_done = 1'b0;

    always #5 clk = ~clk;

    lcd_char_ctrl #(.NUM_COLS(NC), .NUM_ROWS(NR), .CLK_DIV(CD), .INIT_WAIT(IW),
                    .CLEAR_WAIT(CW), .AUTO_REFRESH(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .refresh_req(refresh_req), .busy(busy), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_db(lcd_db), .lcd_rst(lcd_rst));

    lcd_char_ctrl #(.NUM_COLS(4), .NUM_ROWS(1), .CLK_DIV(1), .INIT_WAIT(10),
                    .CLEAR_WAIT(3), .AUTO_REFRESH(1)) dut_auto (
        .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .refresh_req(req_a), .busy(busy_a), .lcd_en(en_a), .lcd_rs(rs_a),
        .lcd_rw(rw_a), .lcd_db(db_a), .lcd_rst(lrst_a));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] base_of(input int r);
        logic [7:0] bases [4];
        bases = '{8'h00, 8'h40, 8'h14, 8'h54};
        return bases[r];
    endfunction

    task automatic push_cmd(input logic [7:0] d);
        exp_q.push_back({1'b0, d});
    endtask

    task automatic push_pass();
        for (int r = 0; r < NR; r++) begin
            push_cmd(8'h80 | base_of(r));
            for (int c = 0; c < NC; c++) exp_q.push_back({1'b1, model[r * NC + c]});
        end
    endtask

    // Monitor: one scoreboard pop per enable rise, and each enable pulse width.
    logic prev_en = 1'b0;
    int   en_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
            en_run  = 0;
        end else begin
            if (lcd_en) begin
                if (!prev_en) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_byte: got rs=%0b db=%0h, none expected", lcd_rs, lcd_db);
                    end else begin
                        chk("byte", 32'({lcd_rs, lcd_db}), 32'(exp_q.pop_front()));
                    end
                end
                en_run++;
            end else if (prev_en) begin
                chk("en_width", en_run, CD);
                en_run = 0;
            end
            prev_en = lcd_en;
        end
    end

    task automatic do_write(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < TOTAL) model[a] = d;
    endtask

    task automatic pulse_refresh();
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 5000) begin
            fails++;
            $display("FAIL %s_timeout: busy=%0b queued=%0d, required idle with empty queue", nm, busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic power_up();
        int first_en = -1, low_at = -1;
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) model[i] = 8'h20;
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(lcd_en), 0);
        chk("rst_rs", 32'(lcd_rs), 0);
        chk("rst_rw", 32'(lcd_rw), 0);
        chk("rst_db", 32'(lcd_db), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_lcd_rst", 32'(lcd_rst), 0);
        rst = 1'b0;
        push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h06); push_cmd(8'h01);
        #1;
        chk("pwrup_lcd_rst", 32'(lcd_rst), 1);
        chk("pwrup_busy", 32'(busy), 1);
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk);
            if (lcd_en && first_en < 0) first_en = cyc;
            if (!busy) begin
                low_at = cyc;
                break;
            end
        end
        chk("first_en_cycle", first_en, IW + CD);
        chk("busy_low_cycle", low_at, IW + 12 * CD + CW);
        chk("init_queue_empty", exp_q.size(), 0);
    endtask

    initial begin : stim
        int n, highs, nr, k;
        logic pe;
        // 1: power-up
        power_up();

        // 2: one pass over an unwritten buffer; busy length
        refresh_req = 1'b1;
        push_pass();
        @(negedge clk);
        refresh_req = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("pass_busy_len", n, PASS_LEN);
        wait_idle("pass_blank");

        // 3: HELLO on row 0, 'W' at row 1 col 0
        do_write(0, 8'h48); do_write(1, 8'h45); do_write(2, 8'h4C);
        do_write(3, 8'h4C); do_write(4, 8'h4F); do_write(NC, 8'h57);
        push_pass();
        pulse_refresh();
        wait_idle("pass_hello");

        // 4: three requests during a pass give exactly one follow-up pass
        push_pass();
        pulse_refresh();
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse_refresh();
            repeat (15) @(negedge clk);
        end
        push_pass();
        wait_idle("pass_pending");
        highs = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy) highs++;
        end
        chk("no_extra_pass", highs, 0);

        // 5: mid-pass writes: unsent index shows now, sent index next pass, out-of-range ignored
        model[20] = 8'h41;
        push_pass();
        pulse_refresh();
        repeat (25) @(negedge clk);
        do_write(20, 8'h41);
        do_write(0, 8'h42);
        do_write(31, 8'h55);
        pulse_refresh();
        push_pass();
        wait_idle("pass_midwrite");

        // random writes (including out-of-range addresses) followed by a pass
        for (int it = 0; it < 6; it++) begin
            k = $urandom_range(0, 6);
            for (int w = 0; w < k; w++) do_write($urandom_range(0, 31), 8'($urandom));
            push_pass();
            pulse_refresh();
            wait_idle("pass_random");
        end

        // 6: reset during the enable phase of char 7 of row 0
        push_pass();
        pulse_refresh();
        nr = 0;
        pe = 1'b0;
        for (int i = 0; i < 500 && nr < 9; i++) begin
            @(negedge clk);
            if (lcd_en && !pe) nr++;
            pe = lcd_en;
        end
        chk("char7_reached", nr, 9);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_en", 32'(lcd_en), 0);
        chk("abort_db", 32'(lcd_db), 0);
        chk("abort_busy", 32'(busy), 1);
        exp_q.delete();
        power_up();
        push_pass();
        pulse_refresh();
        wait_idle("pass_after_reset");

        n = 0;
        while (!auto_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!auto_done) begin
            fails++;
            $display("FAIL auto_timeout: auto checker did not finish");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // AUTO_REFRESH build: after the single idle cycle following init, busy never falls
    // and the bytes repeat row command 0x80 followed by four spaces.
    initial begin : auto_chk
        int n, lows, rises;
        logic pe;
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        n = 0;
        while (busy_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy_a) begin
            fails++;
            $display("FAIL auto_init: busy still %0b, required 0 after init", busy_a);
        end
        lows = 0;
        rises = 0;
        pe = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (!busy_a) lows++;
            if (en_a && !pe) begin
                chk("auto_byte", 32'({rs_a, db_a}), 32'((rises % 5 == 0) ? 9'h080 : 9'h120));
                rises++;
            end
            pe = en_a;
        end
        chk("auto_busy_low", lows, 0);
        chk("auto_rises", rises, 200);
        auto_done = 1'b1;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
